// File: rtl/mptw_pte_fetch.sv
// Page-table-entry fetch engine: one table read in flight, with flush and drain handling.
// Optional macro MPTW_PTE_CHECK_EN enables the fetched-PTE validity fault check.
package mptw_pkg;
  typedef enum logic [0:0] {
    MPT_FLUSH_NONE = 1'b0,
    MPT_FLUSH_REQ  = 1'b1
  } mptw_flush_ctrl_e;

  typedef enum logic [0:0] {
    MPT_FLUSHED_NONE      = 1'b0,
    MPT_FLUSHED_COMPLETED = 1'b1
  } mptw_flush_status_e;
endpackage

module mptw_pte_fetch
  import mptw_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int IDX_WIDTH  = 9,
  parameter int PTE_WIDTH  = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            s_data_valid,
  output logic                            s_data_ready,
  input  logic [ADDR_WIDTH+IDX_WIDTH-1:0] s_data_data,
  output logic                            m_data_valid,
  input  logic                            m_data_ready,
  output logic [PTE_WIDTH:0]              m_data_data,
  output logic                            mem_req_valid_o,
  input  logic                            mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]           mem_req_addr_o,
  input  logic                            mem_rsp_valid_i,
  input  logic [PTE_WIDTH-1:0]            mem_rsp_data_i,
  input  mptw_flush_ctrl_e                s_ctrl_flush,
  output mptw_flush_status_e              m_status_flushed,
  output logic                            m_status_busy,
  output logic                            m_status_stalled
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [IDX_WIDTH-1:0]    idx_q;
  logic [PTE_WIDTH-1:0]    pte_q;
  logic [ADDR_WIDTH-1:0]   idx_ext;
  logic                    flush;
  logic                    flush_done;
  logic                    accept;
  logic                    rsp_cap;
  logic                    fault;

  assign flush = (s_ctrl_flush != MPT_FLUSH_NONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // A flush either finishes now (nothing outstanding at memory) or parks in DRAIN
  // until the already-issued read returns and can be swallowed.
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    accept     = 1'b0;
    rsp_cap    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (flush) begin
          flush_done = 1'b1;
        end else if (s_data_valid) begin
          accept  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (flush) begin
          if (mem_req_ready_i) begin
            state_d = S_DRAIN;
          end else begin
            state_d    = S_IDLE;
            flush_done = 1'b1;
          end
        end else if (mem_req_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid_i) begin
          if (flush) begin
            state_d    = S_IDLE;
            flush_done = 1'b1;
          end else begin
            state_d = S_OUT;
            rsp_cap = 1'b1;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_OUT: begin
        if (flush) begin
          state_d    = S_IDLE;
          flush_done = 1'b1;
        end else if (m_data_ready) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (mem_rsp_valid_i) begin
          state_d    = S_IDLE;
          flush_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs are forced inactive while reset is held.
  always_comb begin
    s_data_ready     = 1'b0;
    m_data_valid     = 1'b0;
    mem_req_valid_o  = 1'b0;
    m_status_stalled = 1'b0;
    m_status_busy    = 1'b0;
    m_status_flushed = MPT_FLUSHED_NONE;
    if (rst_ni) begin
      m_status_busy = (state_q != S_IDLE);
      unique case (state_q)
        S_IDLE: s_data_ready = 1'b1;
        S_REQ: begin
          mem_req_valid_o  = 1'b1;
          m_status_stalled = !mem_req_ready_i;
        end
        S_OUT: begin
          m_data_valid     = 1'b1;
          m_status_stalled = !m_data_ready;
        end
        default: ;
      endcase
      if (flush_done) m_status_flushed = MPT_FLUSHED_COMPLETED;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q <= '0;
      idx_q  <= '0;
      pte_q  <= '0;
    end else begin
      if (accept)  {base_q, idx_q} <= s_data_data;
      if (rsp_cap) pte_q <= mem_rsp_data_i;
    end
  end

  // Entries are 8 bytes; the sum wraps naturally at the address width.
  assign idx_ext        = ADDR_WIDTH'(idx_q);
  assign mem_req_addr_o = base_q + (idx_ext << 3);

`ifdef MPTW_PTE_CHECK_EN
  function automatic logic pte_fault(input logic [PTE_WIDTH-1:0] pte);
    return (pte[0] == 1'b0) || (pte[PTE_WIDTH-1 -: 8] != 8'd0);
  endfunction

  logic fault_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      fault_q <= 1'b0;
    else if (rsp_cap) fault_q <= pte_fault(mem_rsp_data_i);
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign m_data_data = {fault, pte_q};

endmodule

// File: tb/tb_mptw_pte_fetch.sv
// Self-checking bench for mptw_pte_fetch: directed scenarios plus randomized transactions
// checked against a transaction-level reference model.
module tb_mptw_pte_fetch;
  import mptw_pkg::*;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              s_data_valid;
  logic              s_data_ready;
  logic [72:0]       s_data_data;
  logic              m_data_valid;
  logic              m_data_ready;
  logic [64:0]       m_data_data;
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic [63:0]       mem_req_addr_o;
  logic              mem_rsp_valid_i;
  logic [63:0]       mem_rsp_data_i;
  mptw_flush_ctrl_e  s_ctrl_flush;
  mptw_flush_status_e m_status_flushed;
  logic              m_status_busy;
  logic              m_status_stalled;

  int n_tests = 0;
  int n_fail  = 0;

  mptw_pte_fetch dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .s_data_valid     (s_data_valid),
    .s_data_ready     (s_data_ready),
    .s_data_data      (s_data_data),
    .m_data_valid     (m_data_valid),
    .m_data_ready     (m_data_ready),
    .m_data_data      (m_data_data),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_rsp_valid_i  (mem_rsp_valid_i),
    .mem_rsp_data_i   (mem_rsp_data_i),
    .s_ctrl_flush     (s_ctrl_flush),
    .m_status_flushed (m_status_flushed),
    .m_status_busy    (m_status_busy),
    .m_status_stalled (m_status_stalled)
  );

  always #5 clk = ~clk;

  // Reference model: entry address and expected output word from the rules directly.
  function automatic logic [63:0] model_addr(input logic [63:0] base, input logic [8:0] idx);
    logic [63:0] off;
    off = 64'(idx) * 64'd8;
    return base + off;
  endfunction

  function automatic logic model_fault(input logic [63:0] pte);
`ifdef MPTW_PTE_CHECK_EN
    return (pte % 64'd2 == 64'd0) || ((pte / 64'h0100_0000_0000_0000) != 64'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_data_valid    = 1'b0;
    s_data_data     = '0;
    m_data_ready    = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    s_ctrl_flush    = MPT_FLUSH_NONE;
  endtask

  // Drives an accept and returns with the DUT in its request phase.
  task automatic start_txn(input logic [63:0] base, input logic [8:0] idx);
    s_data_valid = 1'b1;
    s_data_data  = {base, idx};
    cyc();
    s_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    idle_inputs();
    rst_ni          = 1'b0;
    s_data_valid    = 1'b1;
    mem_req_ready_i = 1'b1;
    m_data_ready    = 1'b1;
    mem_rsp_valid_i = 1'b1;
    s_ctrl_flush    = MPT_FLUSH_REQ;
    cyc(); cyc();
    n_tests++;
    if ({s_data_ready, m_data_valid, mem_req_valid_o, m_status_busy, m_status_stalled} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_handshakes got=%b want=00000",
               {s_data_ready, m_data_valid, mem_req_valid_o, m_status_busy, m_status_stalled});
    end
    n_tests++;
    if (m_data_data !== 65'd0 || mem_req_addr_o !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_data got data=%h addr=%h want 0/0", m_data_data, mem_req_addr_o);
    end
    n_tests++;
    if (m_status_flushed !== MPT_FLUSHED_NONE) begin
      n_fail++;
      $display("FAIL reset_flushed got=%0d want=%0d", m_status_flushed, MPT_FLUSHED_NONE);
    end
    idle_inputs();
    rst_ni = 1'b1;
    cyc();
    // Reset asserted mid-transaction while the result is being presented.
    d = 64'hDEAD_BEEF_0000_1235;
    start_txn(64'h1000, 9'd3);
    mem_req_ready_i = 1'b1;
    cyc();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = d;
    cyc();
    mem_rsp_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    n_tests++;
    if (m_data_valid !== 1'b0 || m_status_busy !== 1'b0 || m_data_data !== 65'd0 || mem_req_addr_o !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_midtxn got valid=%b busy=%b data=%h addr=%h want 0/0/0/0",
               m_data_valid, m_status_busy, m_data_data, mem_req_addr_o);
    end
    cyc();
    rst_ni = 1'b1;
    #1;
    n_tests++;
    if (s_data_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready got=%b want=1", s_data_ready);
    end
  endtask

  task automatic test_basic();
    logic [63:0] d;
    d = {$urandom, $urandom};
    idle_inputs();
    #1;
    n_tests++;
    if (s_data_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_idle_ready got=%b want=1", s_data_ready);
    end
    start_txn(64'h8000_0000, 9'd5);
    mem_req_ready_i = 1'b1;
    #1;
    n_tests++;
    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 64'h8000_0028 || s_data_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_req got valid=%b addr=%h sready=%b want 1/0000000080000028/0",
               mem_req_valid_o, mem_req_addr_o, s_data_ready);
    end
    cyc();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = d;
    #1;
    n_tests++;
    if (m_data_valid !== 1'b0 || mem_req_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_wait got mvalid=%b reqvalid=%b want 0/0", m_data_valid, mem_req_valid_o);
    end
    cyc();
    mem_rsp_valid_i = 1'b0;
    m_data_ready    = 1'b1;
    #1;
    n_tests++;
    if (m_data_valid !== 1'b1 || m_data_data !== {model_fault(d), d}) begin
      n_fail++;
      $display("FAIL basic_out got valid=%b data=%h want 1/%h", m_data_valid, m_data_data, {model_fault(d), d});
    end
    cyc();
    m_data_ready = 1'b0;
    #1;
    n_tests++;
    if (s_data_ready !== 1'b1 || m_data_valid !== 1'b0 || m_status_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done got sready=%b mvalid=%b busy=%b want 1/0/0", s_data_ready, m_data_valid, m_status_busy);
    end
  endtask

  task automatic test_wrap();
    idle_inputs();
    start_txn(64'hFFFF_FFFF_FFFF_FFF8, 9'd1);
    #1;
    n_tests++;
    if (mem_req_addr_o !== 64'd0) begin
      n_fail++;
      $display("FAIL wrap_addr got=%h want=0000000000000000", mem_req_addr_o);
    end
    // Flush while the request is still unaccepted: dropped immediately.
    s_ctrl_flush = MPT_FLUSH_REQ;
    #1;
    n_tests++;
    if (m_status_flushed !== MPT_FLUSHED_COMPLETED) begin
      n_fail++;
      $display("FAIL flush_req_noready got=%0d want=%0d", m_status_flushed, MPT_FLUSHED_COMPLETED);
    end
    cyc();
    s_ctrl_flush = MPT_FLUSH_NONE;
    #1;
    n_tests++;
    if (s_data_ready !== 1'b1 || m_status_flushed !== MPT_FLUSHED_NONE) begin
      n_fail++;
      $display("FAIL flush_req_noready_after got sready=%b flushed=%0d want 1/0", s_data_ready, m_status_flushed);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    logic [63:0] a;
    int stall_bad;
    stall_bad = 0;
    d = 64'h0000_1234_5678_9ABD;
    a = model_addr(64'h0000_0040_0000_0000, 9'd511);
    idle_inputs();
    start_txn(64'h0000_0040_0000_0000, 9'd511);
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = {$urandom, $urandom};
      #1;
      if (m_status_stalled !== 1'b1 || mem_req_valid_o !== 1'b1 || mem_req_addr_o !== a) stall_bad++;
      cyc();
    end
    n_tests++;
    if (stall_bad != 0) begin
      n_fail++;
      $display("FAIL bp_req_stall got %0d bad cycles want 0 (addr=%h want %h)", stall_bad, mem_req_addr_o, a);
    end
    mem_rsp_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    #1;
    n_tests++;
    if (m_status_stalled !== 1'b0 || mem_req_addr_o !== a) begin
      n_fail++;
      $display("FAIL bp_req_release got stalled=%b addr=%h want 0/%h", m_status_stalled, mem_req_addr_o, a);
    end
    cyc();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = d;
    cyc();
    stall_bad = 0;
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = ~d;
      #1;
      if (m_status_stalled !== 1'b1 || m_data_valid !== 1'b1 || m_data_data !== {model_fault(d), d}) stall_bad++;
      cyc();
    end
    n_tests++;
    if (stall_bad != 0) begin
      n_fail++;
      $display("FAIL bp_out_stall got %0d bad cycles want 0 (data=%h want %h)", stall_bad, m_data_data, {model_fault(d), d});
    end
    mem_rsp_valid_i = 1'b0;
    m_data_ready    = 1'b1;
    #1;
    n_tests++;
    if (m_status_stalled !== 1'b0 || m_data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_out_release got stalled=%b valid=%b want 0/1", m_status_stalled, m_data_valid);
    end
    cyc();
    m_data_ready = 1'b0;
  endtask

  task automatic test_flush_wait();
    idle_inputs();
    start_txn(64'h2000, 9'd7);
    mem_req_ready_i = 1'b1;
    cyc();
    mem_req_ready_i = 1'b0;
    s_ctrl_flush    = MPT_FLUSH_REQ;
    #1;
    n_tests++;
    if (m_status_flushed !== MPT_FLUSHED_NONE) begin
      n_fail++;
      $display("FAIL flush_wait_cycle got=%0d want=%0d", m_status_flushed, MPT_FLUSHED_NONE);
    end
    cyc();
    // First drain cycle, with the flush still held: must remain draining.
    m_data_ready = 1'b1;
    #1;
    n_tests++;
    if (m_status_busy !== 1'b1 || {s_data_ready, m_data_valid, mem_req_valid_o} !== 3'b000
        || m_status_flushed !== MPT_FLUSHED_NONE) begin
      n_fail++;
      $display("FAIL drain_hold got busy=%b hs=%b flushed=%0d want 1/000/0", m_status_busy,
               {s_data_ready, m_data_valid, mem_req_valid_o}, m_status_flushed);
    end
    cyc();
    s_ctrl_flush    = MPT_FLUSH_NONE;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 64'h0F0F_0F0F_0F0F_0F0F;
    #1;
    n_tests++;
    if (m_status_flushed !== MPT_FLUSHED_COMPLETED || m_data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_rsp got flushed=%0d mvalid=%b want 1/0", m_status_flushed, m_data_valid);
    end
    cyc();
    mem_rsp_valid_i = 1'b0;
    #1;
    n_tests++;
    if (s_data_ready !== 1'b1 || m_data_valid !== 1'b0 || m_status_flushed !== MPT_FLUSHED_NONE) begin
      n_fail++;
      $display("FAIL drain_exit got sready=%b mvalid=%b flushed=%0d want 1/0/0", s_data_ready, m_data_valid, m_status_flushed);
    end
    m_data_ready = 1'b0;
  endtask

  task automatic test_flush_misc();
    idle_inputs();
    // Flush coinciding with the request handshake.
    start_txn(64'h3000, 9'd2);
    mem_req_ready_i = 1'b1;
    s_ctrl_flush    = MPT_FLUSH_REQ;
    #1;
    n_tests++;
    if (m_status_flushed !== MPT_FLUSHED_NONE) begin
      n_fail++;
      $display("FAIL flush_req_hs got=%0d want=%0d", m_status_flushed, MPT_FLUSHED_NONE);
    end
    cyc();
    mem_req_ready_i = 1'b0;
    s_ctrl_flush    = MPT_FLUSH_NONE;
    #1;
    n_tests++;
    if (m_status_busy !== 1'b1 || mem_req_valid_o !== 1'b0 || s_data_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_req_hs_drain got busy=%b reqvalid=%b sready=%b want 1/0/0", m_status_busy, mem_req_valid_o, s_data_ready);
    end
    mem_rsp_valid_i = 1'b1;
    cyc();
    mem_rsp_valid_i = 1'b0;
    // Flush while presenting the result.
    start_txn(64'h4000, 9'd1);
    mem_req_ready_i = 1'b1;
    cyc();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 64'h55;
    cyc();
    mem_rsp_valid_i = 1'b0;
    s_ctrl_flush    = MPT_FLUSH_REQ;
    #1;
    n_tests++;
    if (m_status_flushed !== MPT_FLUSHED_COMPLETED) begin
      n_fail++;
      $display("FAIL flush_out got=%0d want=%0d", m_status_flushed, MPT_FLUSHED_COMPLETED);
    end
    cyc();
    s_ctrl_flush = MPT_FLUSH_NONE;
    #1;
    n_tests++;
    if (m_data_valid !== 1'b0 || s_data_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_out_after got mvalid=%b sready=%b want 0/1", m_data_valid, s_data_ready);
    end
    // Flush in the same cycle as the response: response swallowed.
    start_txn(64'h5000, 9'd4);
    mem_req_ready_i = 1'b1;
    cyc();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    s_ctrl_flush    = MPT_FLUSH_REQ;
    #1;
    n_tests++;
    if (m_status_flushed !== MPT_FLUSHED_COMPLETED) begin
      n_fail++;
      $display("FAIL flush_wait_rsp got=%0d want=%0d", m_status_flushed, MPT_FLUSHED_COMPLETED);
    end
    cyc();
    mem_rsp_valid_i = 1'b0;
    // Flush in idle with a pending input: the input is dropped.
    s_data_valid = 1'b1;
    s_data_data  = {64'h6000, 9'd1};
    #1;
    n_tests++;
    if (m_data_valid !== 1'b0 || m_status_flushed !== MPT_FLUSHED_COMPLETED) begin
      n_fail++;
      $display("FAIL flush_idle got mvalid=%b flushed=%0d want 0/1", m_data_valid, m_status_flushed);
    end
    cyc();
    s_data_valid = 1'b0;
    s_ctrl_flush = MPT_FLUSH_NONE;
    #1;
    n_tests++;
    if (m_status_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_after got busy=%b want 0", m_status_busy);
    end
  endtask

  task automatic test_fault();
    logic [63:0] pats [2];
    pats[0] = 64'h0;
    pats[1] = 64'h1;
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      start_txn(64'h7000, 9'(k));
      mem_req_ready_i = 1'b1;
      cyc();
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = pats[k];
      cyc();
      mem_rsp_valid_i = 1'b0;
      m_data_ready    = 1'b1;
      #1;
      n_tests++;
`ifdef MPTW_PTE_CHECK_EN
      if (m_data_data[64] !== (k == 0)) begin
        n_fail++;
        $display("FAIL fault_pat%0d got=%b want=%b", k, m_data_data[64], (k == 0));
      end
`else
      if (m_data_data[64] !== 1'b0) begin
        n_fail++;
        $display("FAIL fault_pat%0d got=%b want=0", k, m_data_data[64]);
      end
`endif
      cyc();
      m_data_ready = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [63:0] base, d, a;
    logic [8:0]  idx;
    int wreq, wrsp, wout, lat, budget;
    idle_inputs();
    for (int t = 0; t < 150; t++) begin
      base = {$urandom, $urandom};
      if (t % 5 == 0) base = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(255));
      idx  = 9'($urandom);
      d    = {$urandom, $urandom};
      if (t % 4 == 1) d = d & 64'h00FF_FFFF_FFFF_FFFF;
      wreq = $urandom_range(2);
      wrsp = $urandom_range(2);
      wout = $urandom_range(2);
      a    = model_addr(base, idx);
      start_txn(base, idx);
      lat = 1;
      for (int i = 0; i < wreq; i++) begin
        cyc();
        lat++;
      end
      mem_req_ready_i = 1'b1;
      #1;
      n_tests++;
      if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== a) begin
        n_fail++;
        $display("FAIL rand%0d_addr got valid=%b addr=%h want 1/%h", t, mem_req_valid_o, mem_req_addr_o, a);
      end
      cyc();
      lat++;
      mem_req_ready_i = 1'b0;
      for (int i = 0; i < wrsp; i++) begin
        cyc();
        lat++;
      end
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = d;
      cyc();
      lat++;
      mem_rsp_valid_i = 1'b0;
      budget = 20;
      while (m_data_valid !== 1'b1 && budget > 0) begin
        cyc();
        lat++;
        budget--;
      end
      n_tests++;
      if (m_data_valid !== 1'b1 || lat != 3 + wreq + wrsp) begin
        n_fail++;
        $display("FAIL rand%0d_latency got valid=%b lat=%0d want 1/%0d", t, m_data_valid, lat, 3 + wreq + wrsp);
      end
      for (int i = 0; i < wout; i++) cyc();
      m_data_ready = 1'b1;
      #1;
      n_tests++;
      if (m_data_data !== {model_fault(d), d}) begin
        n_fail++;
        $display("FAIL rand%0d_data got=%h want=%h", t, m_data_data, {model_fault(d), d});
      end
      cyc();
      m_data_ready = 1'b0;
    end
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_flush_wait();
    test_flush_misc();
    test_fault();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
